// File: rtl/lvds_rx_align.sv
// rtl/lvds_rx_align.sv - LVDS word-alignment trainer, PHY retry and AXIS deframer
module lvds_rx_align #(
  parameter int DATA_W     = 80,
  parameter int USER_W     = 5,
  parameter logic [USER_W+3+DATA_W-1:0] CAL_PATTERN = 88'h005A55FEDCBA9876543210,
  parameter int SETTLE_CYC = 16,
  parameter int MAX_ALIGN  = 32,
  parameter int LOCK_CNT   = 4
) (
  input  logic                       i_pclk,
  input  logic                       i_prst,
  input  logic                       i_rx_ready,
  input  logic                       i_rx_valid,
  input  logic [USER_W+3+DATA_W-1:0] i_rx_data,
  input  logic                       i_recal,
  output logic                       o_align,
  output logic                       o_phy_rst,
  output logic                       o_locked,
  output logic [15:0]                o_align_total,
  output logic [7:0]                 o_retry_cnt,
  output logic [15:0]                o_drop_cnt,
  output logic                       o_axis_tvalid,
  output logic                       o_axis_tlast,
  output logic [DATA_W-1:0]          o_axis_tdata,
  output logic [DATA_W/8-1:0]        o_axis_tkeep,
  output logic [USER_W-1:0]          o_axis_tuser,
  input  logic                       i_axis_tready
);

  localparam int WORD_W = USER_W + 3 + DATA_W;
  localparam int NB     = DATA_W / 8;
  localparam int SET_W  = $clog2(SETTLE_CYC + 1);
  localparam int ATT_W  = $clog2(MAX_ALIGN + 1);
  localparam int MCH_W  = $clog2(LOCK_CNT + 1);

  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);
  localparam logic [ATT_W-1:0] ALIGN_LAST  = ATT_W'(MAX_ALIGN - 1);
  localparam logic [MCH_W-1:0] LOCK_LAST   = MCH_W'(LOCK_CNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    SETTLE,
    CHECK,
    PHY_RST,
    LOCKED
  } state_t;

  state_t             state;
  logic [SET_W-1:0]   settle_cnt;
  logic [ATT_W-1:0]   attempts;
  logic [MCH_W-1:0]   match_cnt;
  logic [1:0]         phy_cnt;

  logic [2:0]         rx_meta;
  logic [USER_W-1:0]  rx_user;
  logic [DATA_W-1:0]  rx_payload;
  logic               dec_beat;
  logic               dec_last;
  logic [NB-1:0]      dec_keep;
  int                 dec_kept;

  assign rx_payload = i_rx_data[DATA_W-1:0];
  assign rx_meta    = i_rx_data[DATA_W+2:DATA_W];
  assign rx_user    = i_rx_data[WORD_W-1:DATA_W+3];

  // Calibration FSM: settle, compare against the pattern, bitslip, and PHY reset on exhaustion
  always_ff @(posedge i_pclk) begin
    if (i_prst) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      attempts      <= '0;
      match_cnt     <= '0;
      phy_cnt       <= '0;
      o_align       <= 1'b0;
      o_phy_rst     <= 1'b0;
      o_locked      <= 1'b0;
      o_align_total <= '0;
      o_retry_cnt   <= '0;
    end else begin
      o_align   <= 1'b0;
      o_phy_rst <= 1'b0;
      case (state)
        IDLE: state <= WAIT_RDY;
        WAIT_RDY: begin
          match_cnt <= '0;
          if (i_rx_ready) begin
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (!i_rx_ready) begin
            state <= WAIT_RDY;
          end else if (settle_cnt == '0) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        CHECK: begin
          if (!i_rx_ready) begin
            state <= WAIT_RDY;
          end else if (i_rx_valid) begin
            if (i_rx_data == CAL_PATTERN) begin
              match_cnt <= match_cnt + 1'b1;
              if (match_cnt == LOCK_LAST) begin
                state    <= LOCKED;
                o_locked <= 1'b1;
              end
            end else if (i_rx_data != '0) begin
              // An all-zero word is an idle line and is neither a match nor a miss
              match_cnt <= '0;
              o_align   <= 1'b1;
              attempts  <= attempts + 1'b1;
              if (o_align_total != '1) o_align_total <= o_align_total + 16'd1;
              if (attempts == ALIGN_LAST) begin
                phy_cnt <= '0;
                state   <= PHY_RST;
              end else begin
                settle_cnt <= SETTLE_LOAD;
                state      <= SETTLE;
              end
            end
          end
        end
        PHY_RST: begin
          o_phy_rst <= 1'b1;
          phy_cnt   <= phy_cnt + 2'd1;
          if (phy_cnt == 2'd3) begin
            attempts <= '0;
            if (o_retry_cnt != '1) o_retry_cnt <= o_retry_cnt + 8'd1;
            state <= WAIT_RDY;
          end
        end
        LOCKED: begin
          if (!i_rx_ready) begin
            o_locked <= 1'b0;
            state    <= WAIT_RDY;
          end else if (i_recal) begin
            o_locked <= 1'b0;
            attempts <= '0;
            state    <= WAIT_RDY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Word decode: meta 1..2 keep every byte, each step above 2 trims two bytes from the top
  always_comb begin
    dec_keep = '0;
    dec_kept = NB;
    if (rx_meta >= 3'd3) dec_kept = NB - 2 * (int'(rx_meta) - 2);
    if (dec_kept < 0) dec_kept = 0;
    for (int i = 0; i < NB; i++) dec_keep[i] = (i < dec_kept);
    dec_last = (rx_meta >= 3'd2);
    dec_beat = (state == LOCKED) && i_rx_valid && (rx_meta != 3'd0);
  end

  // AXIS output register: hold under backpressure, drop and count beats that cannot be taken
  always_ff @(posedge i_pclk) begin
    if (i_prst) begin
      o_axis_tvalid <= 1'b0;
      o_axis_tlast  <= 1'b0;
      o_axis_tdata  <= '0;
      o_axis_tkeep  <= '0;
      o_axis_tuser  <= '0;
      o_drop_cnt    <= '0;
    end else if (dec_beat) begin
      if (!o_axis_tvalid || i_axis_tready) begin
        o_axis_tvalid <= 1'b1;
        o_axis_tlast  <= dec_last;
        o_axis_tdata  <= rx_payload;
        o_axis_tkeep  <= dec_keep;
        o_axis_tuser  <= rx_user;
      end else if (o_drop_cnt != '1) begin
        o_drop_cnt <= o_drop_cnt + 16'd1;
      end
    end else if (i_axis_tready) begin
      o_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lvds_rx_align.sv
// tb/tb_lvds_rx_align.sv - self-checking bench for lvds_rx_align
module tb_lvds_rx_align;

  localparam int DATA_W = 80;
  localparam int USER_W = 5;
  localparam int WORD_W = USER_W + 3 + DATA_W;
  localparam int NB     = DATA_W / 8;
  localparam logic [WORD_W-1:0] CAL = 88'h005A55FEDCBA9876543210;
  localparam logic [WORD_W-1:0] BAD = 88'h1234;

  logic                i_pclk = 1'b0;
  logic                i_prst, i_rx_ready, i_rx_valid, i_recal, i_axis_tready;
  logic [WORD_W-1:0]   i_rx_data;
  logic                o_align, o_phy_rst, o_locked;
  logic [15:0]         o_align_total, o_drop_cnt;
  logic [7:0]          o_retry_cnt;
  logic                o_axis_tvalid, o_axis_tlast;
  logic [DATA_W-1:0]   o_axis_tdata;
  logic [NB-1:0]       o_axis_tkeep;
  logic [USER_W-1:0]   o_axis_tuser;

  lvds_rx_align #(
    .DATA_W(DATA_W), .USER_W(USER_W), .CAL_PATTERN(CAL),
    .SETTLE_CYC(16), .MAX_ALIGN(4), .LOCK_CNT(4)
  ) dut (
    .i_pclk(i_pclk), .i_prst(i_prst), .i_rx_ready(i_rx_ready), .i_rx_valid(i_rx_valid),
    .i_rx_data(i_rx_data), .i_recal(i_recal), .o_align(o_align), .o_phy_rst(o_phy_rst),
    .o_locked(o_locked), .o_align_total(o_align_total), .o_retry_cnt(o_retry_cnt),
    .o_drop_cnt(o_drop_cnt), .o_axis_tvalid(o_axis_tvalid), .o_axis_tlast(o_axis_tlast),
    .o_axis_tdata(o_axis_tdata), .o_axis_tkeep(o_axis_tkeep), .o_axis_tuser(o_axis_tuser),
    .i_axis_tready(i_axis_tready)
  );

  always #5 i_pclk = ~i_pclk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [NB-1:0]     keep;
    logic              last;
    logic [USER_W-1:0] user;
  } beat_t;

  typedef struct {
    logic [2:0]        meta;
    logic [USER_W-1:0] user;
    logic [DATA_W-1:0] data;
    logic [NB-1:0]     keep;
    logic              last;
    logic              beat;
  } vec_t;

  beat_t sb[$];
  vec_t  vecs[8];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int align_seen = 0;
  int last_align_cyc = -1;
  int min_gap = 1000000;
  int phy_rises = 0;
  int phy_rise_cyc = 0;
  int phy_run = 0;
  int last_phy_run = 0;
  logic phy_prev = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] mkword(input logic [2:0] meta, input logic [USER_W-1:0] user,
                                               input logic [DATA_W-1:0] data);
    return {user, meta, data};
  endfunction

  function automatic beat_t mkbeat(input logic [DATA_W-1:0] data, input logic [NB-1:0] keep,
                                   input logic last, input logic [USER_W-1:0] user);
    beat_t b;
    b.data = data; b.keep = keep; b.last = last; b.user = user;
    return b;
  endfunction

  // one clock; the scoreboard pops on handshakes that occur at this edge
  task automatic step();
    beat_t e;
    if (o_axis_tvalid && i_axis_tready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got beat %0h expected none", o_axis_tdata);
      end else begin
        e = sb.pop_front();
        chk("sb_tdata", o_axis_tdata, e.data);
        chk("sb_tkeep", o_axis_tkeep, e.keep);
        chk("sb_tlast", o_axis_tlast, e.last);
        chk("sb_tuser", o_axis_tuser, e.user);
      end
    end
    @(posedge i_pclk);
    #1;
    cyc++;
    if (o_align) begin
      if (last_align_cyc >= 0 && (cyc - last_align_cyc) < min_gap) min_gap = cyc - last_align_cyc;
      last_align_cyc = cyc;
      align_seen++;
    end
    if (o_phy_rst) begin
      if (!phy_prev) begin
        phy_rises++;
        phy_rise_cyc = cyc;
      end
      phy_run++;
    end else if (phy_prev) begin
      last_phy_run = phy_run;
      phy_run = 0;
    end
    phy_prev = o_phy_rst;
  endtask

  task automatic wait_lock(input string name);
    int n;
    n = 0;
    while (!o_locked && n < 300) begin
      step();
      n++;
    end
    chk(name, o_locked, 1'b1);
  endtask

  initial begin
    int n;
    int rises;
    string nm;

    vecs[0] = '{3'd1, 5'h01, 80'h1111, 10'h3FF, 1'b0, 1'b1};
    vecs[1] = '{3'd2, 5'h02, 80'h2222, 10'h3FF, 1'b1, 1'b1};
    vecs[2] = '{3'd3, 5'h03, 80'h3333, 10'h0FF, 1'b1, 1'b1};
    vecs[3] = '{3'd4, 5'h04, 80'h4444, 10'h03F, 1'b1, 1'b1};
    vecs[4] = '{3'd5, 5'h05, 80'h5555, 10'h00F, 1'b1, 1'b1};
    vecs[5] = '{3'd6, 5'h06, 80'h6666, 10'h003, 1'b1, 1'b1};
    vecs[6] = '{3'd7, 5'h07, 80'h7777, 10'h000, 1'b1, 1'b1};
    vecs[7] = '{3'd0, 5'h1F, 80'h8888, 10'h000, 1'b0, 1'b0};

    i_prst = 1'b1; i_rx_ready = 1'b1; i_rx_valid = 1'b1; i_rx_data = CAL;
    i_recal = 1'b0; i_axis_tready = 1'b1;
    repeat (3) step();

    chk("rst_locked", o_locked, 1'b0);
    chk("rst_align", o_align, 1'b0);
    chk("rst_phy_rst", o_phy_rst, 1'b0);
    chk("rst_align_total", o_align_total, 16'd0);
    chk("rst_retry", o_retry_cnt, 8'd0);
    chk("rst_drop", o_drop_cnt, 16'd0);
    chk("rst_tvalid", o_axis_tvalid, 1'b0);

    // clean lock: cycle 1 is IDLE, lock is visible in cycle 1+1+16+4+1
    i_prst = 1'b0;
    align_seen = 0;
    n = 0;
    while (!o_locked && n < 200) begin
      step();
      n++;
    end
    chk("lock_cycle", n + 1, 23);
    chk("lock_no_align", align_seen, 0);
    chk("lock_align_total", o_align_total, 16'd0);

    i_recal = 1'b1; step(); i_recal = 1'b0;
    chk("recal_unlock", o_locked, 1'b0);
    wait_lock("recal_relock");

    i_rx_ready = 1'b0; step(); i_rx_ready = 1'b1;
    chk("rdyloss_unlock", o_locked, 1'b0);
    wait_lock("rdyloss_relock");

    // misalignment: three mismatches, then the pattern
    i_recal = 1'b1; step(); i_recal = 1'b0;
    i_rx_data = BAD;
    align_seen = 0; last_align_cyc = -1; min_gap = 1000000;
    n = 0;
    while (align_seen < 3 && n < 200) begin
      step();
      n++;
    end
    i_rx_data = CAL;
    wait_lock("mis_relock");
    chk("mis_pulses", align_seen, 3);
    chk("mis_gap", min_gap, 17);
    chk("mis_align_total", o_align_total, 16'd3);

    // decode table
    for (int i = 0; i < 8; i++) begin
      i_rx_valid = 1'b1;
      i_rx_data  = mkword(vecs[i].meta, vecs[i].user, vecs[i].data);
      if (vecs[i].beat) sb.push_back(mkbeat(vecs[i].data, vecs[i].keep, vecs[i].last, vecs[i].user));
      step();
      nm = $sformatf("dec_tvalid_m%0d", vecs[i].meta);
      chk(nm, o_axis_tvalid, vecs[i].beat);
      i_rx_valid = 1'b0;
      step();
    end

    // backpressure: five beats with the sink stalled
    i_axis_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_rx_valid = 1'b1;
      i_rx_data  = mkword(3'd1, 5'(k + 1), 80'hA000 + 80'(k));
      if (k == 0) sb.push_back(mkbeat(80'hA000, 10'h3FF, 1'b0, 5'd1));
      step();
      chk("bp_hold_data", o_axis_tdata, 80'hA000);
    end
    chk("bp_drops", o_drop_cnt, 16'd4);
    i_axis_tready = 1'b1;
    i_rx_data = mkword(3'd2, 5'd9, 80'hB0B0);
    sb.push_back(mkbeat(80'hB0B0, 10'h3FF, 1'b1, 5'd9));
    step();
    chk("bp_new_loaded", o_axis_tdata, 80'hB0B0);
    chk("bp_no_drop", o_drop_cnt, 16'd4);
    i_rx_valid = 1'b0;
    step();

    // held beat survives loss of lock
    i_axis_tready = 1'b0;
    i_rx_valid = 1'b1;
    i_rx_data = mkword(3'd4, 5'd3, 80'hC0DE);
    sb.push_back(mkbeat(80'hC0DE, 10'h03F, 1'b1, 5'd3));
    step();
    i_rx_valid = 1'b0;
    i_rx_ready = 1'b0;
    step();
    step();
    chk("held_unlock", o_locked, 1'b0);
    chk("held_tvalid", o_axis_tvalid, 1'b1);
    chk("held_tdata", o_axis_tdata, 80'hC0DE);
    i_axis_tready = 1'b1;
    step();
    chk("held_released", o_axis_tvalid, 1'b0);
    i_rx_ready = 1'b1;
    i_rx_valid = 1'b1;
    i_rx_data = CAL;
    wait_lock("held_relock");

    // retry: constant mismatch
    i_recal = 1'b1; step(); i_recal = 1'b0;
    i_rx_data = BAD;
    align_seen = 0; phy_rises = 0;
    n = 0;
    while (!o_phy_rst && n < 500) begin
      step();
      n++;
    end
    chk("retry_pulses", align_seen, 4);
    chk("retry_phy_delay", phy_rise_cyc - last_align_cyc, 1);
    chk("retry_align_total", o_align_total, 16'd7);
    n = 0;
    while (o_phy_rst && n < 20) begin
      step();
      n++;
    end
    chk("retry_phy_len", last_phy_run, 4);
    chk("retry_cnt1", o_retry_cnt, 8'd1);
    n = 0;
    while (o_retry_cnt != 8'hFF && n < 30000) begin
      step();
      n++;
    end
    chk("retry_reach_sat", o_retry_cnt, 8'hFF);
    rises = phy_rises;
    repeat (200) step();
    chk("retry_sat_hold", o_retry_cnt, 8'hFF);
    chk("retry_continues", (phy_rises - rises) >= 2, 1'b1);

    // reset in the middle of SETTLE
    n = 0;
    while (!o_align && n < 200) begin
      step();
      n++;
    end
    repeat (3) step();
    i_prst = 1'b1;
    step();
    chk("prst_locked", o_locked, 1'b0);
    chk("prst_align", o_align, 1'b0);
    chk("prst_phy_rst", o_phy_rst, 1'b0);
    chk("prst_align_total", o_align_total, 16'd0);
    chk("prst_retry", o_retry_cnt, 8'd0);
    chk("prst_drop", o_drop_cnt, 16'd0);
    chk("prst_tvalid", o_axis_tvalid, 1'b0);
    chk("prst_tdata", o_axis_tdata, 80'd0);
    chk("prst_tkeep", o_axis_tkeep, 10'd0);
    chk("prst_tlast", o_axis_tlast, 1'b0);
    chk("prst_tuser", o_axis_tuser, 5'd0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lvds_rx_align.md
# lvds_rx_align

Parametrised successor to the camera LVDS receiver's calibration and deframing logic, running entirely in the parallel-word clock domain. It trains word alignment against a programmable calibration pattern and requires several consecutive matches before declaring lock. After a bounded number of failed align attempts it issues a PHY reset and retries. It supports re-calibration on request, decodes locked words into an AXI-Stream with computed tkeep/tlast, and counts alignment attempts, PHY retries and dropped beats. It sits between the LVDS DDR deserialiser and the AXIS clock-crossing buffer.

## Interface
- DATA_W, 80, payload bits per word; multiple of 16.
- USER_W, 5, sideband user bits per word.
- CAL_PATTERN, 88'h005A55FEDCBA9876543210, calibration word; width USER_W+3+DATA_W.
- SETTLE_CYC, 16, cycles waited after each align pulse before the next compare; ≥1.
- MAX_ALIGN, 32, align pulses allowed before a PHY reset; ≥1.
- LOCK_CNT, 4, consecutive pattern matches required to lock; ≥1.
- i_pclk  in  1  clock for all logic.
- i_prst  in  1  reset; synchronous and active-high.
- i_rx_ready  in  1  deserialiser ready.
- i_rx_valid  in  1  i_rx_data valid this cycle.
- i_rx_data  in  USER_W+3+DATA_W  word laid out as {user, meta[2:0], data}.
- i_recal  in  1  pulse; forces re-calibration.
- o_align  out  1  one-cycle word-align (bitslip) pulse to the deserialiser.
- o_phy_rst  out  1  deserialiser reset, held 4 cycles.
- o_locked  out  1  calibration complete.
- o_align_total  out  16  saturating count of align pulses.
- o_retry_cnt  out  8  saturating count of PHY resets.
- o_drop_cnt  out  16  saturating count of dropped beats.
- o_axis_tvalid / o_axis_tlast  out  1 / 1  stream valid, end of line.
- o_axis_tdata  out  DATA_W  payload.
- o_axis_tkeep  out  DATA_W/8  byte enables.
- o_axis_tuser  out  USER_W  user sideband.
- i_axis_tready  in  1  sink ready.

## Operation
- FSM states: IDLE, WAIT_RDY, SETTLE, CHECK, PHY_RST, LOCKED.
- IDLE: entered on reset; moves to WAIT_RDY next cycle.
- WAIT_RDY: clears match_cnt. When i_rx_ready=1, loads settle counter with SETTLE_CYC-1 and goes to SETTLE.
- SETTLE: decrements the settle counter every cycle; goes to CHECK at 0.
- CHECK: acts only when i_rx_valid=1.
  - word == CAL_PATTERN: match_cnt+1. At LOCK_CNT matches, go to LOCKED.
  - word == 0 (idle line): no action.
  - any other word: clear match_cnt, pulse o_align, increment attempt counter and o_align_total.
    - If attempts then equals MAX_ALIGN, go to PHY_RST.
    - Otherwise reload the settle counter and go to SETTLE.
- PHY_RST: drives o_phy_rst for 4 cycles, increments o_retry_cnt, clears attempts, then goes to WAIT_RDY.
- LOCKED: o_locked=1. i_recal=1 leads to WAIT_RDY with attempts cleared.
- Ready loss: i_rx_ready=0 in SETTLE, CHECK or LOCKED goes to WAIT_RDY and clears o_locked.
- Priority when events coincide: i_prst > ready loss > i_recal > compare.
- Decode, only in LOCKED with i_rx_valid=1:
  - beat = meta≠0.
  - tlast = meta≥2.
  - NB = DATA_W/8. Kept bytes: NB for meta 1–2; max(NB−2·(meta−2), 0) for meta≥3.
  - tkeep is contiguous from bit 0. With meta=7 and NB=10, the beat is forwarded with tkeep=0 and tlast=1.
- Output register follows AXIS rules: payload is held stable while tvalid=1 and tready=0.
- A new beat arriving while the held beat is unaccepted is discarded and o_drop_cnt increments.
- Same cycle tready=1 and new beat: the new beat is loaded and nothing is dropped.
- A held beat survives loss of lock until accepted.
- Counters saturate at all-ones.

## Timing
- Reset values: every output is 0; FSM in IDLE; internal counters 0.
- o_align: asserted the cycle after the mismatching word is sampled; single cycle.
- o_locked: rises the cycle after the LOCK_CNT-th match is sampled.
- Minimum spacing between align pulses: SETTLE_CYC+1 cycles.
- Stream latency: 1 cycle from i_rx_data to o_axis_* (registered outputs).
- o_phy_rst: rises the cycle after the MAX_ALIGN-th pulse. After the 4-cycle reset, WAIT_RDY holds until i_rx_ready is seen again.

## Test plan
- Lock on clean pattern: ready=1 and CAL_PATTERN on every cycle -> o_locked=1 at cycle 1+1+16+4+1; o_align never pulses; o_align_total=0.
- Misalignment: 3 non-zero mismatches, then pattern -> exactly 3 o_align pulses, each ≥17 cycles apart; o_align_total=3; lock follows.
- Retry: constant mismatch with MAX_ALIGN=4 -> 4 pulses, then o_phy_rst high for 4 cycles and o_retry_cnt=1; the sequence repeats, and o_retry_cnt saturates at 255.
- Decode (locked, DATA_W=80):
  - meta=1 -> tkeep=0x3FF, tlast=0.
  - meta=3 -> tkeep=0x0FF, tlast=1.
  - meta=6 -> tkeep=0x003.
  - meta=0 -> no beat.
- Backpressure: tready=0 with 5 beats arriving -> first beat held stable, o_drop_cnt=4; tready=1 with a beat arriving that cycle -> new beat loaded, no drop.
- Disruption: i_recal or i_rx_ready=0 while locked -> o_locked=0 next cycle and relock follows; i_prst mid-SETTLE -> every output is 0 the next cycle.
